// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED mode controller: display modes,
// controller FSM states and bounce direction.
package led_ctrl_pkg;

    // Display modes as seen on the command port
    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    // Controller FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_PAUSE = 2'd1;
    localparam state_t ST_LOAD  = 2'd2;

    // Travel direction of the single lit bit in bounce mode
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Fewest LEDs for which rotate and bounce are meaningful
    localparam int LED_NUM_MIN = 2;

    // A zero period behaves like a period of one
    function automatic logic [31:0] sanitize_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Programmable step timer: pulses tick once every `period` enabled
// cycles. Counter holds while disabled and clears on clr.
module led_step_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] period_s;
    logic [PERIOD_W-1:0] last;

    // Terminal count from the sanitized period, so period-1 never wraps
    always_comb begin
        period_s = (period == '0) ? PERIOD_W'(1) : period;
        last     = period_s - PERIOD_W'(1);
        tick     = en && (cnt_q == last);
    end

    // Count while enabled, restart after each tick or on clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED bank controller: sequences rotate/bounce/blink patterns paced
// by a step timer, with a valid/ready command port and a pause input.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int LED_NUM        = 6,
    parameter int PERIOD_W       = 32,
    parameter int DEFAULT_PERIOD = 27_000_000,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                pause,
    output logic                step_tick,
    output logic [1:0]          mode_cur,
    output logic [LED_NUM-1:0]  led
);

    localparam logic [LED_NUM-1:0] PAT_LSB = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] PAT_MSB = {1'b1, {(LED_NUM-1){1'b0}}};
    localparam logic [LED_NUM-1:0] PAT_ALL = {LED_NUM{1'b1}};
    localparam logic [LED_NUM-1:0] LED_OFF =
        (LED_ACTIVE_LOW != 0) ? {LED_NUM{1'b1}} : {LED_NUM{1'b0}};

    state_t              state_q;
    state_t              state_d;
    mode_t               mode_q;
    logic [PERIOD_W-1:0] period_q;
    logic [LED_NUM-1:0]  pattern_q;
    logic [LED_NUM-1:0]  pat_next;
    logic [LED_NUM-1:0]  pat_init;
    dir_t                dir_q;
    dir_t                dir_next;
    logic                accept;
    logic                tmr_en;
    logic                tmr_clr;

    // Ready outside LOAD, and never while reset is held
    always_comb begin
        cmd_ready = rst_n && (state_q != ST_LOAD);
        accept    = cmd_valid && cmd_ready;
        tmr_en    = (state_q == ST_RUN) && !accept;
        tmr_clr   = (state_q == ST_LOAD);
    end

    // Controller FSM next state; a command always wins over pause
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept) begin
                    state_d = ST_LOAD;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                state_d = pause ? ST_PAUSE : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    led_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tmr_en),
        .clr    (tmr_clr),
        .period (period_q),
        .tick   (step_tick)
    );

    // Initial pattern for the active mode, applied in LOAD
    always_comb begin
        pat_init = PAT_LSB;
        unique case (mode_q)
            MODE_ROT_L:  pat_init = PAT_LSB;
            MODE_ROT_R:  pat_init = PAT_MSB;
            MODE_BOUNCE: pat_init = PAT_LSB;
            MODE_BLINK:  pat_init = PAT_ALL;
            default:     pat_init = PAT_LSB;
        endcase
    end

    // Pattern after one step; bounce turns around at either end
    always_comb begin
        pat_next = pattern_q;
        dir_next = dir_q;
        unique case (mode_q)
            MODE_ROT_L: begin
                pat_next = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
            end
            MODE_ROT_R: begin
                pat_next = {pattern_q[0], pattern_q[LED_NUM-1:1]};
            end
            MODE_BOUNCE: begin
                if (dir_q == DIR_UP) begin
                    if (pattern_q[LED_NUM-1]) begin
                        dir_next = DIR_DOWN;
                        pat_next = pattern_q >> 1;
                    end else begin
                        pat_next = pattern_q << 1;
                    end
                end else begin
                    if (pattern_q[0]) begin
                        dir_next = DIR_UP;
                        pat_next = pattern_q << 1;
                    end else begin
                        pat_next = pattern_q >> 1;
                    end
                end
            end
            MODE_BLINK: begin
                pat_next = ~pattern_q;
            end
            default: begin
                pat_next = pattern_q;
            end
        endcase
    end

    // FSM state and the command latched on the handshake edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            mode_q   <= MODE_ROT_L;
            period_q <= PERIOD_W'(DEFAULT_PERIOD);
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q   <= mode_t'(cmd_mode);
                period_q <= cmd_period;
            end
        end
    end

    // Pattern restarts in LOAD and advances only on a timer step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= PAT_LSB;
            dir_q     <= DIR_UP;
        end else if (state_q == ST_LOAD) begin
            pattern_q <= pat_init;
            dir_q     <= DIR_UP;
        end else if (step_tick) begin
            pattern_q <= pat_next;
            dir_q     <= dir_next;
        end
    end

    // LED drive register, one cycle behind the pattern
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led <= LED_OFF;
        end else if (LED_ACTIVE_LOW != 0) begin
            led <= ~pattern_q;
        end else begin
            led <= pattern_q;
        end
    end

    // Active mode is exposed straight from its register
    always_comb begin
        mode_cur = mode_q;
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with LED_NUM=6, active-low LEDs
// and a default step period of 4 cycles.
module tb_led_mode_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [31:0] cmd_period;
    logic        pause;
    logic        step_tick;
    logic [1:0]  mode_cur;
    logic [5:0]  led;

    int tests;
    int fails;

    logic [5:0] p;
    logic [5:0] bseq [0:11];

    led_mode_ctrl #(
        .LED_NUM        (6),
        .PERIOD_W       (32),
        .DEFAULT_PERIOD (4),
        .LED_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_period (cmd_period),
        .pause      (pause),
        .step_tick  (step_tick),
        .mode_cur   (mode_cur),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected LED drive is the inverted lit-pattern
    task automatic chk_led(input string tag, input logic [5:0] pat);
        logic [5:0] e;
        e = ~pat;
        chk(tag, {26'd0, led}, {26'd0, e});
    endtask

    task automatic chk_tick(input string tag, input logic exp);
        chk(tag, {31'd0, step_tick}, {31'd0, exp});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bseq = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                 6'b010000, 6'b100000, 6'b010000, 6'b001000,
                 6'b000100, 6'b000010, 6'b000001, 6'b000010};
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'd0;
        cmd_period = 32'd0;
        pause      = 1'b0;

        // 1. reset then run at the default period of 4
        cyc();
        cyc();
        chk_led("rst_led", 6'b000000);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk_tick("rst_tick", 1'b0);
        chk("rst_mode", {30'd0, mode_cur}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("run_ready", {31'd0, cmd_ready}, 32'd1);
        chk_tick("run_c0_tick", 1'b0);
        cyc();
        chk_led("run_c1_led", 6'b000001);
        cyc();
        chk_tick("run_c2_tick", 1'b0);
        cyc();
        for (int j = 0; j < 6; j++) begin
            chk_tick("rotl_tick", 1'b1);
            cyc();
            chk_tick("rotl_notick", 1'b0);
            cyc();
            p = 6'b000001 << ((j + 1) % 6);
            chk_led("rotl_led", p);
            cyc();
            cyc();
        end

        // 5. command on the exact tick cycle (pattern is 000001)
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd1;
        cmd_period = 32'd2;
        #1;
        chk_tick("cmdtick_sup", 1'b0);
        chk("cmdtick_ready", {31'd0, cmd_ready}, 32'd1);
        cyc();
        cmd_valid = 1'b0;
        chk("load_ready", {31'd0, cmd_ready}, 32'd0);
        chk("load_mode", {30'd0, mode_cur}, 32'd1);
        cyc();
        chk_led("cmdtick_noadv", 6'b000001);
        chk("rotr_ready", {31'd0, cmd_ready}, 32'd1);
        chk_tick("rotr_c0_tick", 1'b0);
        cyc();

        // 2. ROT_R with period 2, including wrap back to 100000
        p = 6'b100000;
        for (int k = 0; k < 7; k++) begin
            chk_led("rotr_led", p);
            chk_tick("rotr_tick", 1'b1);
            p = {p[0], p[5:1]};
            cyc();
            cyc();
        end
        cyc();

        // 3. BOUNCE with period 0 steps every cycle
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd2;
        cmd_period = 32'd0;
        #1;
        chk_tick("bnc_acc_tick", 1'b0);
        cyc();
        cmd_valid = 1'b0;
        chk("bnc_load_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bnc_mode", {30'd0, mode_cur}, 32'd2);
        cyc();
        chk_tick("bnc_c0_tick", 1'b1);
        cyc();
        for (int i = 0; i < 12; i++) begin
            chk_led("bnc_led", bseq[i]);
            chk_tick("bnc_tick", 1'b1);
            cyc();
        end

        // 4. pause with the counter frozen at 2 of period 4
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd0;
        cmd_period = 32'd4;
        #1;
        chk_tick("p4_acc_tick", 1'b0);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        pause = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk_tick("pause_tick", 1'b0);
            chk_led("pause_led", 6'b000001);
            cyc();
        end
        pause = 1'b0;
        #1;
        chk_tick("unpause_c0", 1'b0);
        cyc();
        chk_tick("unpause_c1", 1'b0);
        cyc();
        chk_tick("unpause_c2", 1'b1);
        cyc();
        pause = 1'b1;
        cyc();
        chk("pause_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd1;
        cmd_period = 32'd3;
        cyc();
        cmd_valid = 1'b0;
        chk("pload_ready", {31'd0, cmd_ready}, 32'd0);
        cyc();
        chk("ppause_ready", {31'd0, cmd_ready}, 32'd1);
        chk_tick("ppause_tick0", 1'b0);
        cyc();
        chk_led("ppause_led1", 6'b100000);
        chk_tick("ppause_tick1", 1'b0);
        cyc();
        chk_led("ppause_led2", 6'b100000);

        // 6. BLINK with period 3, then a one-cycle reset
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd3;
        cmd_period = 32'd3;
        pause      = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        chk("blink_mode", {30'd0, mode_cur}, 32'd3);
        chk_tick("blink_k0_tick", 1'b0);
        cyc();
        chk_led("blink_k1", 6'b111111);
        cyc();
        chk_tick("blink_k2_tick", 1'b1);
        cyc();
        chk_led("blink_k3", 6'b111111);
        cyc();
        chk_led("blink_k4", 6'b000000);
        cyc();
        chk_tick("blink_k5_tick", 1'b1);
        cyc();
        chk_led("blink_k6", 6'b000000);
        cyc();
        chk_led("blink_k7", 6'b111111);
        rst_n = 1'b0;
        cyc();
        chk_led("rst2_led", 6'b000000);
        chk("rst2_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst2_mode", {30'd0, mode_cur}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk_tick("rst2_c0_tick", 1'b0);
        chk("rst2_rel_ready", {31'd0, cmd_ready}, 32'd1);
        cyc();
        chk_led("rst2_c1_led", 6'b000001);
        cyc();
        chk_tick("rst2_c2_tick", 1'b0);
        cyc();
        chk_tick("rst2_c3_tick", 1'b1);
        cyc();
        cyc();
        chk_led("rst2_c5_led", 6'b000010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Controller that owns the board LED bank and sequences it through selectable display modes: rotate left, rotate right, bounce, blink.
A programmable step timer paces pattern updates.
A valid/ready command port lets a host FSM or button debouncer change the mode and step period at run time.
A pause input freezes the display.

Parameters:
LED_NUM, 6, number of LEDs driven; must be >= 2
PERIOD_W, 32, width of step-period counter and cmd_period
DEFAULT_PERIOD, 27_000_000, step period in clk cycles after reset (1 s at 27 MHz)
LED_ACTIVE_LOW, 1, 1: led bit 0 = lit; 0: led bit 1 = lit

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  host requests mode/period change
cmd_ready  out  1  controller can accept command this cycle
cmd_mode  in  2  0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK
cmd_period  in  PERIOD_W  new step period in cycles; 0 treated as 1
pause  in  1  level; 1 freezes timer and pattern
step_tick  out  1  one-cycle pulse on each pattern step
mode_cur  out  2  currently active mode
led  out  LED_NUM  registered LED drive, polarity per LED_ACTIVE_LOW

Behaviour:
- Reset (rst_n low at clk edge):
  - state RUN; mode ROT_L; period DEFAULT_PERIOD; tick counter 0; bounce dir UP
  - pattern = 0..01; step_tick 0; cmd_ready 0
  - led = all-off (all 1s if LED_ACTIVE_LOW, else all 0s)
- Reset mid-operation discards any in-flight command and restarts timer and pattern.
- FSM states and transitions:
  - RUN: cmd_ready=1. If cmd_valid -> LOAD. Else if pause -> PAUSE.
  - PAUSE: cmd_ready=1. If cmd_valid -> LOAD. Else if !pause -> RUN.
  - LOAD (exactly 1 cycle): cmd_ready=0. Latched command is applied; next state is PAUSE if pause=1, else RUN.
- Command handshake:
  - Transfer occurs when cmd_valid && cmd_ready. mode and period are latched at that edge.
  - In LOAD: counter cleared to 0, dir=UP, pattern set to the mode's initial value:
    - ROT_L 0..01; ROT_R 10..0; BOUNCE 0..01; BLINK all 1s
  - cmd_valid while cmd_ready=0 is ignored; the host holds it.
- Step timer:
  - Counts only in RUN. Held in PAUSE. Cleared in LOAD.
  - When counter == period-1: step_tick=1 (combinational from counter and state), counter -> 0, pattern advances at that edge.
  - period 0 or 1: step every RUN cycle.
  - Step period is exactly `period` cycles.
- Pattern advance:
  - ROT_L: rotate left, MSB wraps to bit 0.
  - ROT_R: rotate right, bit 0 wraps to MSB.
  - BOUNCE: single bit moves up. At MSB, dir flips to DOWN and the same step moves it down; symmetric at bit 0. Full cycle is 2*(LED_NUM-1) steps.
  - BLINK: pattern toggles between all 1s and all 0s.
- Simultaneous events:
  - Command accept in the same cycle as a would-be tick: the command wins, the tick is suppressed, step_tick=0.
  - pause rising in the same cycle as a tick in RUN: the tick still occurs, then the FSM enters PAUSE.
- Output: led register updates every cycle = pattern (or ~pattern if active-low), 1-cycle latency from pattern. mode_cur is a registered copy of the active mode.
- Arithmetic: counter and compare are PERIOD_W wide. period-1 is computed on the sanitized period (>=1), so no underflow.

Decomposition:
- Package led_ctrl_pkg holds:
  - mode encodings ROT_L/ROT_R/BOUNCE/BLINK (2-bit typedef)
  - FSM state typedef RUN/PAUSE/LOAD
  - dir encoding UP/DOWN
  - LED_NUM_MIN=2
- Sub-module led_step_timer: counter with enable, clear, period input and tick output. Reusable by other LED and blink blocks.

Test Plan (LED_NUM=6, LED_ACTIVE_LOW=1, DEFAULT_PERIOD=4):
1. Reset then run:
   - During reset: led=111111, cmd_ready=0.
   - After release: step_tick on the 4th cycle; pattern 000001->000010; led=111101 one cycle later; ticks every 4 cycles.
   - Wrap 100000->000001 after 6 steps.
2. Command ROT_R, period 2:
   - cmd_ready drops for 1 cycle (LOAD).
   - pattern=100000, then 010000 after 2 RUN cycles, stepping every 2 cycles; wrap 000001->100000.
   - mode_cur=1.
3. Command BOUNCE, period 0 (treated as 1):
   - Steps every cycle: 000001,000010,000100,001000,010000,100000,010000,...,000001,000010.
   - Period is 10 steps.
4. Pause mid-count:
   - Pause at counter=2 in period 4; hold 10 cycles: no step_tick, led stable.
   - Release: next tick exactly 2 cycles later.
   - A command accepted while paused lands in PAUSE with the new initial pattern.
5. Command asserted on the exact tick cycle: step_tick=0 that cycle; pattern = new mode's initial value, not the advanced value.
6. BLINK with period 3, then rst_n low for 1 cycle mid-run:
   - Before reset: led alternates 000000/111111 every 3 cycles.
   - After reset: mode ROT_L, pattern 000001, first tick 4 cycles after release.
